// File: rtl/fifo_lib_pkg.sv
// Shared types and helpers for the FWFT FIFO consumer blocks.
//   pack_state_e    : packer FSM states (S_FILL, S_CLOSE)
//   lane_idx_width(): width of a lane pointer for a given lane count
//   keep_mask()     : lane count -> contiguous low-lane keep mask
package fifo_lib_pkg;

    typedef enum logic [0:0] {
        S_FILL,
        S_CLOSE
    } pack_state_e;

    // At least one bit so a pointer is always a legal vector.
    function automatic int unsigned lane_idx_width(input int unsigned ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    // n lanes filled -> lanes [n-1:0] set. n=32 wraps to all ones, which is correct.
    function automatic logic [31:0] keep_mask(input int unsigned n);
        return (32'd1 << n) - 32'd1;
    endfunction

endpackage

// File: rtl/fwft_pack_out_reg.sv
// One-entry valid/ready holding register for the width packer output.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   load        : capture load_* this cycle (caller guarantees the slot is free)
//   load_data/load_keep/load_last : word to capture
//   ready       : downstream accept
//   valid/data/keep/last : registered output stream
module fwft_pack_out_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned KEEP_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [KEEP_W-1:0] load_keep,
    input  logic              load_last,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [KEEP_W-1:0] keep,
    output logic              last
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [KEEP_W-1:0] keep_q;
    logic              last_q;

    // A load takes priority over ready: a word accepted in the same cycle as a
    // new load is simply replaced, keeping valid high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= load_data;
            keep_q  <= load_keep;
            last_q  <= load_last;
        end else if (ready) begin
            valid_q <= 1'b0;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign keep  = keep_q;
    assign last  = last_q;

endmodule

// File: rtl/fwft_width_packer.sv
// Packs RATIO narrow words popped from an FWFT FIFO into one wide word on a
// valid/ready stream. Partial words close on flush or idle timeout.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   fifo_empty          : FIFO empty flag
//   fifo_rd_data        : FIFO head word (valid while fifo_empty=0)
//   fifo_rd_en          : pop strobe
//   flush               : single-cycle request to close the current partial word
//   m_valid/m_ready     : output handshake
//   m_data              : packed word, lane 0 in the low bits
//   m_keep              : lane-valid mask
//   m_last              : word was closed by flush
//   busy                : partial word, held output or pending flush present
module fwft_width_packer
    import fifo_lib_pkg::*;
#(
    parameter int unsigned IN_WIDTH       = 8,
    parameter int unsigned RATIO          = 4,
    parameter int unsigned OUT_WIDTH      = IN_WIDTH * RATIO,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fifo_empty,
    input  logic [IN_WIDTH-1:0]  fifo_rd_data,
    output logic                 fifo_rd_en,
    input  logic                 flush,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic [RATIO-1:0]     m_keep,
    output logic                 m_last,
    output logic                 busy
);

    localparam int unsigned IDX_W = lane_idx_width(RATIO);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    pack_state_e          state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [OUT_WIDTH-1:0] buf_q, buf_d, buf_ins;
    logic                 flush_pend_q, flush_pend_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 out_free, idx_nz, idx_last, cnt_sat, timeout_hit;
    logic                 close_req, close_fire, pop;
    logic                 load, load_last;
    logic [OUT_WIDTH-1:0] load_data;
    logic [RATIO-1:0]     load_keep;

    assign out_free    = ~m_valid | m_ready;
    assign idx_nz      = (idx_q != '0);
    assign idx_last    = (idx_q == IDX_W'(RATIO - 1));
    assign cnt_sat     = (cnt_q == CNT_W'(TIMEOUT_CYCLES));
    assign timeout_hit = cnt_sat & (TIMEOUT_CYCLES != 0);
    assign close_req   = idx_nz & (flush_pend_q | timeout_hit);

    // rst_n gates the pop so a reset cycle never consumes a FIFO word.
    // The last lane may only be popped when the output slot can take the word.
    assign pop = rst_n & ~fifo_empty & ~flush_pend_q & ~close_req & (~idx_last | out_free);
    assign fifo_rd_en = pop;

    // Buffer with the FIFO head written into the current lane.
    always_comb begin
        buf_ins = buf_q;
        buf_ins[idx_q * IN_WIDTH +: IN_WIDTH] = fifo_rd_data;
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        buf_d        = buf_q;
        flush_pend_d = flush_pend_q;
        cnt_d        = cnt_q;
        close_fire   = 1'b0;
        load         = 1'b0;
        load_data    = buf_q;
        load_keep    = '0;
        load_last    = 1'b0;

        unique case (state_q)
            S_FILL: begin
                if (close_req) begin
                    if (out_free) begin
                        close_fire = 1'b1;
                    end else begin
                        state_d = S_CLOSE;
                    end
                end
            end
            S_CLOSE: begin
                if (out_free) begin
                    close_fire = 1'b1;
                    state_d    = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase

        // pop and close_fire are mutually exclusive: pop requires ~close_req.
        if (pop) begin
            buf_d = buf_ins;
            idx_d = idx_q + IDX_W'(1);
            cnt_d = '0;
            if (idx_last) begin
                load      = 1'b1;
                load_data = buf_ins;
                load_keep = '1;
                buf_d     = '0;
            end
        end else if (close_fire) begin
            load      = 1'b1;
            load_data = buf_q;
            load_keep = RATIO'(keep_mask(int'(idx_q)));
            load_last = flush_pend_q;
            idx_d     = '0;
            buf_d     = '0;
            cnt_d     = '0;
        end else if (idx_nz && !cnt_sat) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // A pending flush with nothing packed is dropped; a new flush request
        // (even one arriving while already pending) wins over any clear.
        if (close_fire || (flush_pend_q && !idx_nz)) begin
            flush_pend_d = 1'b0;
        end
        if (flush) begin
            flush_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_FILL;
            idx_q        <= '0;
            buf_q        <= '0;
            flush_pend_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            buf_q        <= buf_d;
            flush_pend_q <= flush_pend_d;
            cnt_q        <= cnt_d;
        end
    end

    fwft_pack_out_reg #(
        .DATA_W (OUT_WIDTH),
        .KEEP_W (RATIO)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (load_data),
        .load_keep (load_keep),
        .load_last (load_last),
        .ready     (m_ready),
        .valid     (m_valid),
        .data      (m_data),
        .keep      (m_keep),
        .last      (m_last)
    );

    assign busy = idx_nz | m_valid | flush_pend_q;

endmodule
